boot_loader: RTL and testbench

//  Program-image loader between the mips core and exmemory. Receives a byte stream
//  (2-byte header + word payload), packs bytes into 32-bit words and writes them to

---
 rtl/boot_loader_pkg.sv | 18 +
 rtl/boot_loader_byte_packer.sv | 48 ++++
 rtl/boot_loader.sv | 136 +++++++++++++
 tb/tb_boot_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Purpose: shared types and constants for the boot loader slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package boot_loader_pkg;

    // Loader FSM encodings. DONE and ERR are terminal until reset.
    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Purpose: packs a big-endian byte stream into 32-bit words.
// Latency: word_full is combinational with the 4th accept; packed word is valid the next cycle.
// Backpressure: none internally; the caller only asserts accept on a real transfer.
//
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_clear            restart byte counting (wins over i_accept)
//   i_accept, i_data   one byte shifted in per accept
//   o_byte_cnt         bytes accepted into the current word (mod 4)
//   o_word             shift register contents, newest byte in [7:0]
//   o_word_full        pulses on the accept that completes a word
module boot_loader_byte_packer
    import boot_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_data,
    output logic [1:0]  o_byte_cnt,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else begin
            if (i_accept) begin
                r_word <= {r_word[23:0], i_data};
            end
            if (i_clear) begin
                r_cnt <= 2'd0;
            end else if (i_accept) begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    assign o_byte_cnt  = r_cnt;
    assign o_word      = r_word;
    assign o_word_full = i_accept && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/boot_loader.sv
// Purpose: loads a byte-stream program image into exmemory, then hands the memory port to the core.
// Latency: one write cycle after the 4th byte of each word; >=5 cycles per word; cpu_reset falls on the first DONE cycle.
// Backpressure: in_ready drops during the write cycle and after load/error; a held byte is taken in the next DATA cycle.
//
// Ports:
//   i_clk, i_reset                        clock, async active-low reset
//   i_in_valid, i_in_data, o_in_ready     byte stream (2-byte word count, then payload)
//   i_cpu_memwrite/adr/writedata          core memory port (used only after load)
//   o_mem_memwrite/adr/writedata          exmemory port
//   o_cpu_reset                           registered active-high core reset
//   o_load_done, o_load_err               load status
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               ADDR_WORDS = 256,
    parameter logic [WIDTH-1:0] BASE_ADR   = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    input  logic [7:0]       i_in_data,
    output logic             o_in_ready,
    input  logic             i_cpu_memwrite,
    input  logic [WIDTH-1:0] i_cpu_adr,
    input  logic [WIDTH-1:0] i_cpu_writedata,
    output logic             o_mem_memwrite,
    output logic [WIDTH-1:0] o_mem_adr,
    output logic [WIDTH-1:0] o_mem_writedata,
    output logic             o_cpu_reset,
    output logic             o_load_done,
    output logic             o_load_err
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_count;
    logic [15:0] r_word_cnt;
    logic        r_cpu_reset;

    logic             w_xfer;
    logic             w_hdr_last;
    logic [15:0]      w_hdr_count;
    logic [1:0]       w_byte_cnt;
    logic [31:0]      w_word;
    logic             w_word_full;
    logic             w_last_word;
    logic [WIDTH-1:0] w_wr_adr;

    assign o_in_ready = (r_state == ST_HDR) || (r_state == ST_DATA);
    assign w_xfer     = i_in_valid && o_in_ready;

    // The packer is shared by header and payload: the header's first byte
    // sits in w_word[7:0] while the second byte is on the input.
    boot_loader_byte_packer u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_reset),
        .i_clear     (w_hdr_last),
        .i_accept    (w_xfer),
        .i_data      (i_in_data),
        .o_byte_cnt  (w_byte_cnt),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    assign w_hdr_last  = (r_state == ST_HDR) && w_xfer &&
                         (w_byte_cnt == 2'(HDR_BYTES - 1));
    assign w_hdr_count = {w_word[7:0], i_in_data};
    assign w_last_word = ((r_word_cnt + 16'd1) == r_count);
    // Address arithmetic wraps at WIDTH bits.
    assign w_wr_adr    = BASE_ADR + (WIDTH'(r_word_cnt) << 2);

    always_comb begin
        w_next          = r_state;
        o_mem_memwrite  = 1'b0;
        o_mem_adr       = w_wr_adr;
        o_mem_writedata = WIDTH'(w_word);
        case (r_state)
            ST_HDR: begin
                if (w_hdr_last) begin
                    if (w_hdr_count == 16'd0) begin
                        w_next = ST_DONE;
                    end else if (32'(w_hdr_count) > 32'(ADDR_WORDS)) begin
                        w_next = ST_ERR;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_word_full) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                o_mem_memwrite = 1'b1;
                w_next         = w_last_word ? ST_DONE : ST_DATA;
            end
            ST_DONE: begin
                o_mem_memwrite  = i_cpu_memwrite;
                o_mem_adr       = i_cpu_adr;
                o_mem_writedata = i_cpu_writedata;
            end
            ST_ERR: begin
                w_next = ST_ERR;
            end
            default: begin
                w_next = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_HDR;
            r_count     <= 16'd0;
            r_word_cnt  <= 16'd0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_hdr_last) begin
                r_count <= w_hdr_count;
            end
            if (r_state == ST_WRITE) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
            // Registered from next state so it drops on the first DONE cycle.
            r_cpu_reset <= (w_next != ST_DONE);
        end
    end

    assign o_cpu_reset = r_cpu_reset;
    assign o_load_done = (r_state == ST_DONE);
    assign o_load_err  = (r_state == ST_ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Purpose: scoreboard bench for boot_loader; stimulus pushes expected writes, a monitor pops them.
// Latency: checks sampled on the falling edge, inputs driven 1ns after the rising edge.
// Backpressure: the byte driver holds each byte until the loader shows ready.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        cpu_memwrite;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_writedata;
    logic        mem_memwrite;
    logic [31:0] mem_adr;
    logic [31:0] mem_writedata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;

    always #5 clk = ~clk;

    boot_loader #(.WIDTH(32), .ADDR_WORDS(256), .BASE_ADR(32'd0)) dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_in_valid      (in_valid),
        .i_in_data       (in_data),
        .o_in_ready      (in_ready),
        .i_cpu_memwrite  (cpu_memwrite),
        .i_cpu_adr       (cpu_adr),
        .i_cpu_writedata (cpu_writedata),
        .o_mem_memwrite  (mem_memwrite),
        .o_mem_adr       (mem_adr),
        .o_mem_writedata (mem_writedata),
        .o_cpu_reset     (cpu_reset),
        .o_load_done     (load_done),
        .o_load_err      (load_err)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] img[$];
    int          errors = 0;
    int          checks = 0;
    bit          chk_rdy = 1'b0;
    // Idle cycles inserted before each byte of the gapped image (header + 3 words).
    // Entry 6 is 0 so the first byte of word 1 is held through the WRITE cycle.
    int          gtab[14] = '{2, 0, 1, 3, 0, 2, 0, 1, 2, 0, 3, 1, 0, 2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every loader write must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mem_memwrite === 1'b1 && load_done !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: adr %h dat %h with nothing expected",
                             mem_adr, mem_writedata);
                end else begin
                    e = sb.pop_front();
                    check("wr_adr", mem_adr, e.adr);
                    check("wr_dat", mem_writedata, e.dat);
                end
            end
            if (chk_rdy && rst_n === 1'b1 && load_done !== 1'b1 && load_err !== 1'b1) begin
                check("ready_vs_write", 32'(in_ready), 32'(!mem_memwrite));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_memwrite", 32'(mem_memwrite), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Offers one byte after `gap` idle cycles and holds it until it transfers.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout: byte %h not accepted, in_ready %b", b, in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h5A;
    endtask

    task automatic send_image(input logic [15:0] cnt, input logic [31:0] w[$], input bit gaps);
        int k;
        for (int i = 0; i < w.size(); i++) begin
            sb.push_back('{adr: 32'(i * 4), dat: w[i]});
        end
        k = 0;
        send_byte(cnt[15:8], gaps ? gtab[k] : 0); k++;
        send_byte(cnt[7:0],  gaps ? gtab[k] : 0); k++;
        for (int i = 0; i < w.size(); i++) begin
            for (int j = 3; j >= 0; j--) begin
                send_byte(w[i][j*8 +: 8], (gaps && k < 14) ? gtab[k] : 0);
                k++;
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = 8'h00;
        // Junk on the core port while loading must never reach memory.
        cpu_memwrite  = 1'b1;
        cpu_adr       = 32'hDEAD_BEE0;
        cpu_writedata = 32'hBAD0_BAD0;
        do_reset();

        // 1: three words back to back
        img = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        send_image(16'd3, img, 1'b0);
        @(negedge clk);
        check("t1_last_write", 32'(mem_memwrite), 32'd1);
        check("t1_cpu_reset_in_write", 32'(cpu_reset), 32'd1);
        check("t1_ready_in_write", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t1_cpu_reset_fell", 32'(cpu_reset), 32'd0);
        check("t1_load_done", 32'(load_done), 32'd1);
        check("t1_load_err", 32'(load_err), 32'd0);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // 2: same image with idle gaps and a byte held through WRITE
        do_reset();
        chk_rdy = 1'b1;
        send_image(16'd3, img, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk_rdy = 1'b0;
        check("t2_load_done", 32'(load_done), 32'd1);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 3: zero-length image
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check("t3_load_done", 32'(load_done), 32'd1);
        check("t3_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t3_in_ready", 32'(in_ready), 32'd0);

        // 4a: 256 words is the largest legal count
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check("t4a_no_err", 32'(load_err), 32'd0);
        check("t4a_in_ready", 32'(in_ready), 32'd1);

        // 4b: 257 words is an error; later bytes are refused
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        check("t4b_load_err", 32'(load_err), 32'd1);
        check("t4b_in_ready", 32'(in_ready), 32'd0);
        check("t4b_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t4b_load_done", 32'(load_done), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (8) @(negedge clk);
        check("t4b_still_not_ready", 32'(in_ready), 32'd0);
        check("t4b_no_write", 32'(mem_memwrite), 32'd0);
        check("t4b_still_err", 32'(load_err), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // 5: reset after two payload bytes, then a fresh image from address 0
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset();
        img = '{32'hCAFEF00D, 32'h01020304};
        send_image(16'd2, img, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t5_load_done", 32'(load_done), 32'd1);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // 6: core port passes straight through after the load
        cpu_memwrite  = 1'b1;
        cpu_adr       = 32'd252;
        cpu_writedata = 32'd13;
        #1;
        check("t6_memwrite", 32'(mem_memwrite), 32'd1);
        check("t6_adr", mem_adr, 32'd252);
        check("t6_wdata", mem_writedata, 32'd13);
        cpu_memwrite  = 1'b0;
        cpu_adr       = 32'd8;
        cpu_writedata = 32'h0BAD_F00D;
        #1;
        check("t6_memwrite_low", 32'(mem_memwrite), 32'd0);
        check("t6_adr2", mem_adr, 32'd8);
        check("t6_wdata2", mem_writedata, 32'h0BAD_F00D);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
